// File: rtl/bsg_vanilla_remote_req_responder.sv
// Tile-side responder: runs remote load/store/AMO requests against a 1RW DMEM and returns load responses.
// Optional feature macro BSG_VANILLA_STORE_ACK_EN: when defined, stores also return a (data = 0) response.

package bsg_vanilla_remote_req_pkg;

    localparam logic [1:0] AMO_SWAP = 2'b00;
    localparam logic [1:0] AMO_OR   = 2'b01;
    localparam logic [1:0] AMO_ADD  = 2'b10;

    typedef struct packed {
        logic       float_wb;
        logic       is_unsigned_op;
        logic       is_byte_op;
        logic       is_hex_op;
        logic [1:0] part_sel;
    } load_info_s;

    typedef struct packed {
        logic        write_not_read;
        logic        is_amo_op;
        logic [1:0]  amo_type;
        logic [3:0]  mask;
        load_info_s  load_info;
        logic [4:0]  reg_id;
        logic [31:0] data;
        logic [31:0] addr;
    } remote_req_s;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  reg_id;
        logic        float_wb;
        logic        is_unsigned_op;
        logic        is_byte_op;
        logic        is_hex_op;
        logic [1:0]  part_sel;
    } remote_load_resp_s;

endpackage

module bsg_vanilla_remote_req_responder
    import bsg_vanilla_remote_req_pkg::*;
#(
    parameter int dmem_addr_width_p = 10
) (
    input  logic                         clk_i,
    input  logic                         reset_i,

    input  logic                         req_v_i,
    input  remote_req_s                  req_i,
    output logic                         req_yumi_o,

    output logic                         dmem_v_o,
    output logic                         dmem_w_o,
    output logic [dmem_addr_width_p-1:0] dmem_addr_o,
    output logic [31:0]                  dmem_data_o,
    output logic [3:0]                   dmem_mask_o,
    input  logic [31:0]                  dmem_data_i,

    output logic                         resp_v_o,
    output remote_load_resp_s            resp_o,
    input  logic                         resp_ready_i
);

    typedef enum logic [1:0] {eIDLE, eREAD, eAMO_WR} state_e;

    state_e            state_q, state_d;
    remote_req_s       req_q, req_d;
    logic              resp_v_q, resp_v_d;
    remote_load_resp_s resp_q, resp_d;
    logic [31:0]       amo_wdata_q, amo_wdata_d;

    logic in_is_store;
    logic accept;

    // Unassigned amo_type 2'b11 falls through to swap.
    function automatic logic [31:0] amo_result(input logic [1:0]  amo_type,
                                               input logic [31:0] old_word,
                                               input logic [31:0] operand);
        logic [31:0] res;
        case (amo_type)
            AMO_OR:  res = old_word | operand;
            AMO_ADD: res = old_word + operand;
            default: res = operand;
        endcase
        return res;
    endfunction

    assign in_is_store = req_i.write_not_read & ~req_i.is_amo_op;

    // A pending response may drain in the same cycle a new request is taken.
    assign accept = ~reset_i & (state_q == eIDLE) & req_v_i & (~resp_v_q | resp_ready_i);

    assign req_yumi_o = accept;
    assign resp_v_o   = resp_v_q;
    assign resp_o     = resp_q;

    always_comb begin
        dmem_v_o    = 1'b0;
        dmem_w_o    = 1'b0;
        dmem_addr_o = req_i.addr[2 +: dmem_addr_width_p];
        dmem_data_o = req_i.data;
        dmem_mask_o = req_i.mask;
        if (state_q == eAMO_WR) begin
            dmem_v_o    = ~reset_i;
            dmem_w_o    = 1'b1;
            dmem_addr_o = req_q.addr[2 +: dmem_addr_width_p];
            dmem_data_o = amo_wdata_q;
            dmem_mask_o = 4'b1111;
        end else if (accept) begin
            dmem_v_o = 1'b1;
            dmem_w_o = in_is_store;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        resp_v_d    = resp_v_q;
        resp_d      = resp_q;
        amo_wdata_d = amo_wdata_q;

        if (resp_v_q & resp_ready_i) begin
            resp_v_d = 1'b0;
        end

        case (state_q)
            eIDLE: begin
                if (accept) begin
                    req_d = req_i;
`ifdef BSG_VANILLA_STORE_ACK_EN
                    state_d = eREAD;
`else
                    if (!in_is_store) begin
                        state_d = eREAD;
                    end
`endif
                end
            end
            eREAD: begin
                resp_v_d              = 1'b1;
                resp_d.data           = dmem_data_i;
                resp_d.reg_id         = req_q.reg_id;
                resp_d.float_wb       = req_q.load_info.float_wb;
                resp_d.is_unsigned_op = req_q.load_info.is_unsigned_op;
                resp_d.is_byte_op     = req_q.load_info.is_byte_op;
                resp_d.is_hex_op      = req_q.load_info.is_hex_op;
                resp_d.part_sel       = req_q.load_info.part_sel;
`ifdef BSG_VANILLA_STORE_ACK_EN
                // No DMEM read was issued for a store, so dmem_data_i is meaningless here.
                if (req_q.write_not_read & ~req_q.is_amo_op) begin
                    resp_d.data           = '0;
                    resp_d.float_wb       = 1'b0;
                    resp_d.is_unsigned_op = 1'b0;
                    resp_d.is_byte_op     = 1'b0;
                    resp_d.is_hex_op      = 1'b0;
                    resp_d.part_sel       = '0;
                end
`endif
                if (req_q.is_amo_op) begin
                    amo_wdata_d = amo_result(req_q.amo_type, dmem_data_i, req_q.data);
                    state_d     = eAMO_WR;
                end else begin
                    state_d = eIDLE;
                end
            end
            eAMO_WR: begin
                state_d = eIDLE;
            end
            default: begin
                state_d = eIDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= eIDLE;
            resp_v_q <= 1'b0;
            resp_q   <= '0;
        end else begin
            state_q  <= state_d;
            resp_v_q <= resp_v_d;
            resp_q   <= resp_d;
        end
    end

    always_ff @(posedge clk_i) begin
        req_q       <= req_d;
        amo_wdata_q <= amo_wdata_d;
    end

    // Byte offset and out-of-range address bits are intentionally dropped.
    logic unused_bits;
    assign unused_bits = ^{req_i.addr[1:0], req_i.addr[31:2+dmem_addr_width_p], req_q};

endmodule

// File: tb/tb_bsg_vanilla_remote_req_responder.sv
// Directed bench for bsg_vanilla_remote_req_responder with a behavioural 1RW DMEM.
// Store-response expectations follow BSG_VANILLA_STORE_ACK_EN.

module tb_bsg_vanilla_remote_req_responder;
    import bsg_vanilla_remote_req_pkg::*;

    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              req_v_i;
    remote_req_s       req_i;
    logic              req_yumi_o;
    logic              dmem_v_o;
    logic              dmem_w_o;
    logic [AW-1:0]     dmem_addr_o;
    logic [31:0]       dmem_data_o;
    logic [3:0]        dmem_mask_o;
    logic [31:0]       dmem_data_i;
    logic              resp_v_o;
    remote_load_resp_s resp_o;
    logic              resp_ready_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    bsg_vanilla_remote_req_responder #(.dmem_addr_width_p(AW)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_i(req_i), .req_yumi_o(req_yumi_o),
        .dmem_v_o(dmem_v_o), .dmem_w_o(dmem_w_o), .dmem_addr_o(dmem_addr_o),
        .dmem_data_o(dmem_data_o), .dmem_mask_o(dmem_mask_o), .dmem_data_i(dmem_data_i),
        .resp_v_o(resp_v_o), .resp_o(resp_o), .resp_ready_i(resp_ready_i)
    );

    always @(posedge clk) begin
        if (dmem_v_o) begin
            if (dmem_w_o) begin
                for (int b = 0; b < 4; b++)
                    if (dmem_mask_o[b]) mem[dmem_addr_o][8*b +: 8] <= dmem_data_o[8*b +: 8];
            end else begin
                dmem_data_i <= mem[dmem_addr_o];
            end
        end
    end

    function automatic remote_req_s mk(input logic wnr, input logic amo, input logic [1:0] at,
                                       input logic [3:0] mask, input logic [31:0] addr,
                                       input logic [31:0] data, input logic [4:0] rid,
                                       input load_info_s li);
        remote_req_s r;
        r.write_not_read = wnr;
        r.is_amo_op      = amo;
        r.amo_type       = at;
        r.mask           = mask;
        r.addr           = addr;
        r.data           = data;
        r.reg_id         = rid;
        r.load_info      = li;
        return r;
    endfunction

    task automatic send(input remote_req_s r, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        req_i   = r;
        req_v_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_yumi_o) begin
                @(posedge clk);
                #1;
                req_v_i = 1'b0;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        req_v_i = 1'b0;
    endtask

    task automatic wait_resp(input int max_cyc, output bit got, output remote_load_resp_s r,
                             output int lat);
        got = 1'b0;
        lat = 0;
        r   = '0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            lat++;
            if (resp_v_o) begin
                got = 1'b1;
                r   = resp_o;
                return;
            end
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        req_v_i = 1'b1;
        req_i   = mk(1'b0, 1'b0, 2'b00, 4'hF, 32'h40, 32'h0, 5'd1, '0);
        repeat (3) @(negedge clk);
        checks++; if (req_yumi_o !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b want 0", req_yumi_o); end
        checks++; if (dmem_v_o !== 1'b0) begin errors++; $display("FAIL reset_dmem_v got %b want 0", dmem_v_o); end
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL reset_resp_v got %b want 0", resp_v_o); end
        checks++; if (resp_o !== '0) begin errors++; $display("FAIL reset_resp got %h want 0", resp_o); end
        req_v_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic test_store_load();
        bit ok, got; int lat; remote_load_resp_s r;
        send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h40, 32'hDEADBEEF, 5'd0, '0), ok);
        checks++; if (!ok) begin errors++; $display("FAIL store_accept got 0 want 1"); end
        checks++; if (mem[10'h10] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_mem got %h want deadbeef", mem[10'h10]); end
        send(mk(1'b0, 1'b0, 2'b00, 4'h0, 32'h40, 32'h0, 5'd5, '0), ok);
        checks++; if (!ok) begin errors++; $display("FAIL load_accept got 0 want 1"); end
        wait_resp(6, got, r, lat);
        checks++; if (!got || lat != 2) begin errors++; $display("FAIL load_latency got %0d want 2", lat); end
        checks++; if (r.data !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got %h want deadbeef", r.data); end
        checks++; if (r.reg_id !== 5'd5) begin errors++; $display("FAIL load_reg_id got %0d want 5", r.reg_id); end
    endtask

    task automatic test_masked_store();
        bit ok, got; int lat; remote_load_resp_s r; load_info_s li;
        send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h40, 32'h11111111, 5'd0, '0), ok);
        send(mk(1'b1, 1'b0, 2'b00, 4'b0100, 32'h40, 32'h00AB0000, 5'd0, '0), ok);
        li = '{float_wb: 1'b0, is_unsigned_op: 1'b1, is_byte_op: 1'b1, is_hex_op: 1'b0, part_sel: 2'd2};
        send(mk(1'b0, 1'b0, 2'b00, 4'h0, 32'h42, 32'h0, 5'd7, li), ok);
        wait_resp(6, got, r, lat);
        checks++; if (!got || r.data !== 32'h11AB1111) begin errors++; $display("FAIL mask_data got %h want 11ab1111", r.data); end
        checks++; if (r.part_sel !== 2'd2) begin errors++; $display("FAIL mask_part_sel got %0d want 2", r.part_sel); end
        checks++; if (r.is_byte_op !== 1'b1 || r.is_unsigned_op !== 1'b1) begin
            errors++; $display("FAIL mask_flags got byte=%b uns=%b want 1 1", r.is_byte_op, r.is_unsigned_op); end
        checks++; if (r.is_hex_op !== 1'b0 || r.float_wb !== 1'b0) begin
            errors++; $display("FAIL mask_flags0 got hex=%b fwb=%b want 0 0", r.is_hex_op, r.float_wb); end
    endtask

    task automatic test_amo();
        bit ok, got; int lat; remote_load_resp_s r;
        logic [31:0] init_t [5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h000000F0, 32'h000000FF, 32'h0000ABCD};
        logic [1:0]  type_t [5] = '{2'b10, 2'b10, 2'b01, 2'b00, 2'b11};
        logic [31:0] opnd_t [5] = '{32'h1, 32'h1, 32'h0000000F, 32'hCAFEF00D, 32'h12345678};
        logic [31:0] exp_t  [5] = '{32'h80000000, 32'h0, 32'h000000FF, 32'hCAFEF00D, 32'h12345678};
        for (int i = 0; i < 5; i++) begin
            send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h80, init_t[i], 5'd0, '0), ok);
`ifdef BSG_VANILLA_STORE_ACK_EN
            wait_resp(6, got, r, lat);
`endif
            send(mk(1'b0, 1'b1, type_t[i], 4'h0, 32'h80, opnd_t[i], 5'd9, '0), ok);
            wait_resp(6, got, r, lat);
            checks++; if (!got || r.data !== init_t[i]) begin
                errors++; $display("FAIL amo%0d_resp got %h want %h", i, r.data, init_t[i]); end
            @(posedge clk);
            #1;
            checks++; if (mem[10'h20] !== exp_t[i]) begin
                errors++; $display("FAIL amo%0d_mem got %h want %h", i, mem[10'h20], exp_t[i]); end
        end
    endtask

    task automatic test_addr_wrap();
        bit ok;
        send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h00001043, 32'hA5A5A5A5, 5'd0, '0), ok);
        @(posedge clk);
        #1;
        checks++; if (mem[10'h10] !== 32'hA5A5A5A5) begin errors++; $display("FAIL wrap_mem got %h want a5a5a5a5", mem[10'h10]); end
    endtask

    task automatic test_backpressure();
        bit ok, got; int lat; remote_load_resp_s r;
        @(negedge clk);
        @(negedge clk);
        resp_ready_i = 1'b0;
        send(mk(1'b0, 1'b0, 2'b00, 4'h0, 32'h40, 32'h0, 5'd3, '0), ok);
        wait_resp(6, got, r, lat);
        checks++; if (!got) begin errors++; $display("FAIL bp_first_resp got 0 want 1"); end
        req_i   = mk(1'b0, 1'b0, 2'b00, 4'h0, 32'h80, 32'h0, 5'd4, '0);
        req_v_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (resp_v_o !== 1'b1 || resp_o.data !== 32'hA5A5A5A5 || resp_o.reg_id !== 5'd3) begin
                errors++; $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=a5a5a5a5", i, resp_v_o, resp_o.data); end
            checks++; if (req_yumi_o !== 1'b0) begin errors++; $display("FAIL bp_yumi%0d got %b want 0", i, req_yumi_o); end
            @(negedge clk);
        end
        resp_ready_i = 1'b1;
        #1;
        checks++; if (req_yumi_o !== 1'b1) begin errors++; $display("FAIL bp_drain_accept got %b want 1", req_yumi_o); end
        @(posedge clk);
        #1;
        req_v_i = 1'b0;
        wait_resp(6, got, r, lat);
        checks++; if (!got || lat != 2 || r.data !== 32'h12345678 || r.reg_id !== 5'd4) begin
            errors++; $display("FAIL bp_second got lat=%0d d=%h id=%0d want 2 12345678 4", lat, r.data, r.reg_id); end
    endtask

    task automatic test_reset_amo_wr();
        bit ok, got; int lat; remote_load_resp_s r;
        send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h100, 32'h00000055, 5'd0, '0), ok);
`ifdef BSG_VANILLA_STORE_ACK_EN
        wait_resp(6, got, r, lat);
`endif
        send(mk(1'b0, 1'b1, 2'b10, 4'h0, 32'h100, 32'h1, 5'd2, '0), ok);
        wait_resp(6, got, r, lat);
        resp_ready_i = 1'b0;
        reset_i      = 1'b1;
        #1;
        checks++; if (dmem_v_o !== 1'b0) begin errors++; $display("FAIL rst_amo_dmem_v got %b want 0", dmem_v_o); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL rst_amo_resp_v got %b want 0", resp_v_o); end
        reset_i      = 1'b0;
        resp_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (mem[10'h40] !== 32'h00000055) begin errors++; $display("FAIL rst_amo_mem got %h want 55", mem[10'h40]); end
        send(mk(1'b0, 1'b0, 2'b00, 4'h0, 32'h100, 32'h0, 5'd6, '0), ok);
        wait_resp(6, got, r, lat);
        checks++; if (!got || r.data !== 32'h00000055) begin errors++; $display("FAIL rst_amo_reload got %h want 55", r.data); end
    endtask

    task automatic test_back_to_back();
`ifndef BSG_VANILLA_STORE_ACK_EN
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            req_i   = mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h200 + 32'(4*i), 32'hB0 + 32'(i), 5'd0, '0);
            req_v_i = 1'b1;
            #1;
            checks++; if (req_yumi_o !== 1'b1) begin errors++; $display("FAIL b2b_yumi%0d got %b want 1", i, req_yumi_o); end
            @(negedge clk);
        end
        req_v_i = 1'b0;
        checks++; if (mem[10'h80] !== 32'hB0 || mem[10'h81] !== 32'hB1 || mem[10'h82] !== 32'hB2) begin
            errors++; $display("FAIL b2b_mem got %h %h %h want b0 b1 b2", mem[10'h80], mem[10'h81], mem[10'h82]); end
`endif
    endtask

    task automatic test_store_ack();
        bit ok, got; int lat; remote_load_resp_s r;
        send(mk(1'b1, 1'b0, 2'b00, 4'hF, 32'h300, 32'h00000077, 5'd9, '0), ok);
        wait_resp(4, got, r, lat);
`ifdef BSG_VANILLA_STORE_ACK_EN
        checks++; if (!got || r.data !== 32'h0 || r.reg_id !== 5'd9) begin
            errors++; $display("FAIL store_ack got v=%b d=%h id=%0d want 1 0 9", got, r.data, r.reg_id); end
`else
        checks++; if (got !== 1'b0) begin errors++; $display("FAIL store_noack got resp=%b want 0", got); end
`endif
    endtask

    initial begin
        reset_i      = 1'b1;
        req_v_i      = 1'b0;
        req_i        = '0;
        resp_ready_i = 1'b1;
        test_reset();
        test_store_load();
        test_masked_store();
        test_amo();
        test_addr_wrap();
        test_backpressure();
        test_reset_amo_wr();
        test_back_to_back();
        test_store_ack();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
